axis_burst_meas_ctrl: RTL and testbench

- Measurement sequencer for AXI-Stream valid activity.
- Selects one of NCH tvalid lines and arms on a start command.
- Measures a programmed number of complete bursts (maximal runs of consecutive tvalid=1 cycles), reporting burst count, last/min/max burst length and total valid cycles.
- Terminates with done, or with timeout if the stream stalls.
- Sits between the register interface (start/config) and the monitored stream taps.

---
 rtl/axis_burst_meas_ctrl.sv | 134 +++++++++++++
 tb/tb_axis_burst_meas_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axis_burst_meas_ctrl.sv
// axis_burst_meas_ctrl: measures burst count/length statistics on one selected AXI-Stream tvalid tap.
// Define AXIS_BURST_MEAS_GAP_EN to add gap_max_o (longest idle run between completed bursts).
module axis_burst_meas_ctrl #(
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [CH_W-1:0] ch_sel_i,
    input  logic [15:0]     nburst_i,
    input  logic [31:0]     timeout_i,
    input  logic [NCH-1:0]  s_tvalid_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            timeout_o,
    output logic [15:0]     burst_cnt_o,
    output logic [31:0]     len_last_o,
    output logic [31:0]     len_min_o,
    output logic [31:0]     len_max_o,
`ifdef AXIS_BURST_MEAS_GAP_EN
    output logic [31:0]     gap_max_o,
`endif
    output logic [31:0]     total_o
);
    typedef enum logic [2:0] {IDLE, SYNC, WAIT, MEAS, DONE} state_t;
    state_t          state;
    logic            v_r, v_sel, fin, tmo, active;
    logic [CH_W-1:0] ch_r, ch_src, ch_eff;
    logic [15:0]     nb_r;
    logic [31:0]     to_r, tcnt, run;
    logic [32:0]     total_sum;
    always_comb begin
        // While idle the live select is used so v_r already tracks the new channel on the start edge.
        ch_src    = (state == IDLE) ? ch_sel_i : ch_r;
        ch_eff    = (32'(ch_src) < NCH) ? ch_src : '0;
        v_sel     = |(s_tvalid_i & (NCH'(1) << ch_eff));
        total_sum = {1'b0, total_o} + {1'b0, run};
        active    = (state == SYNC) || (state == WAIT) || (state == MEAS);
        fin       = (state == MEAS) && !v_r && (burst_cnt_o + 16'd1 == nb_r);
        tmo       = (to_r != '0) && (tcnt + 32'd1 == to_r);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            v_r         <= 1'b0;
            ch_r        <= '0;
            nb_r        <= '0;
            to_r        <= '0;
            tcnt        <= '0;
            run         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
            burst_cnt_o <= '0;
            len_last_o  <= '0;
            len_min_o   <= '0;
            len_max_o   <= '0;
            total_o     <= '0;
        end else begin
            v_r    <= v_sel;
            done_o <= 1'b0;
            if (abort_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        state       <= SYNC;
                        busy_o      <= 1'b1;
                        ch_r        <= ch_sel_i;
                        nb_r        <= (nburst_i == '0) ? 16'd1 : nburst_i;
                        to_r        <= timeout_i;
                        tcnt        <= '0;
                        timeout_o   <= 1'b0;
                        burst_cnt_o <= '0;
                        len_last_o  <= '0;
                        len_min_o   <= '1;
                        len_max_o   <= '0;
                        total_o     <= '0;
                    end
                    SYNC: if (!v_r) state <= WAIT;
                    WAIT: if (v_r) begin
                        state <= MEAS;
                        run   <= 32'd1;
                    end
                    MEAS: if (v_r) run <= &run ? run : run + 32'd1;
                    else begin
                        len_last_o  <= run;
                        len_min_o   <= (run < len_min_o) ? run : len_min_o;
                        len_max_o   <= (run > len_max_o) ? run : len_max_o;
                        total_o     <= total_sum[32] ? '1 : total_sum[31:0];
                        burst_cnt_o <= burst_cnt_o + 16'd1;
                        state       <= fin ? DONE : WAIT;
                        done_o      <= fin;
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
                if (active) begin
                    tcnt <= tcnt + 32'd1;
                    // A final burst ending on the timeout cycle counts as normal completion.
                    if (tmo && !fin) begin
                        state     <= DONE;
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                    end
                end
            end
        end
    end
`ifdef AXIS_BURST_MEAS_GAP_EN
    logic [31:0] gap;
    // The gap preceding a burst is only scored once that burst completes, so the lead-in idle is skipped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gap       <= '0;
            gap_max_o <= '0;
        end else if (!abort_i && state == IDLE && start_i) begin
            gap       <= '0;
            gap_max_o <= '0;
        end else if (!abort_i && state == WAIT && !v_r) begin
            gap <= &gap ? gap : gap + 32'd1;
        end else if (!abort_i && state == MEAS && !v_r) begin
            gap <= 32'd1;
            if (burst_cnt_o != '0 && gap > gap_max_o) gap_max_o <= gap;
        end
    end
`endif
endmodule

// File: tb/tb_axis_burst_meas_ctrl.sv
// tb_axis_burst_meas_ctrl: directed runs with a done_o-driven scoreboard for axis_burst_meas_ctrl.
module tb_axis_burst_meas_ctrl;
    logic        clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0, abort_i = 1'b0;
    logic [1:0]  ch_sel_i = '0;
    logic [15:0] nburst_i = '0;
    logic [31:0] timeout_i = '0;
    logic [3:0]  s_tvalid_i = '0;
    logic        busy_o, done_o, timeout_o;
    logic [15:0] burst_cnt_o;
    logic [31:0] len_last_o, len_min_o, len_max_o, total_o;
`ifdef AXIS_BURST_MEAS_GAP_EN
    logic [31:0] gap_max_o;
`endif

    typedef struct {
        int          cnt;
        logic [31:0] last, mn, mx, total;
        logic        to;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0, cyc = 0, last_fall = 0, start_cyc = 0;

    axis_burst_meas_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .ch_sel_i(ch_sel_i), .nburst_i(nburst_i), .timeout_i(timeout_i), .s_tvalid_i(s_tvalid_i),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .burst_cnt_o(burst_cnt_o),
        .len_last_o(len_last_o), .len_min_o(len_min_o), .len_max_o(len_max_o),
`ifdef AXIS_BURST_MEAS_GAP_EN
        .gap_max_o(gap_max_o),
`endif
        .total_o(total_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Monitor: every done_o pulse consumes one expected result; cyc < 0 means "two cycles after last fall".
    always @(negedge clk) begin
        if (rst_ni && done_o) begin
            if (q.size() == 0) chk("unexpected_done", 32'(done_o), 32'd0);
            else begin
                e = q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc < 0 ? last_fall + 2 : e.cyc));
                chk("burst_cnt", 32'(burst_cnt_o), 32'(e.cnt));
                chk("len_last", len_last_o, e.last);
                chk("len_min", len_min_o, e.mn);
                chk("len_max", len_max_o, e.mx);
                chk("total", total_o, e.total);
                chk("timeout_flag", 32'(timeout_o), 32'(e.to));
            end
        end
    end

    task automatic expect_run(input int cnt, input logic [31:0] last, input logic [31:0] mn,
                              input logic [31:0] mx, input logic [31:0] total, input logic to, input int c);
        q.push_back('{cnt, last, mn, mx, total, to, c});
    endtask

    task automatic start_run(input logic [1:0] ch, input logic [15:0] nb, input logic [31:0] to);
        ch_sel_i  = ch;
        nburst_i  = nb;
        timeout_i = to;
        start_i   = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic burst(input int ch, input int len, input int gap);
        s_tvalid_i[ch] = 1'b1;
        repeat (len) @(negedge clk);
        s_tvalid_i[ch] = 1'b0;
        last_fall = cyc;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_cnt", 32'(burst_cnt_o), 32'd0);
        chk("rst_min", len_min_o, 32'd0);
        chk("rst_total", total_o, 32'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // Basic run on channel 1
        expect_run(3, 2, 2, 7, 13, 1'b0, -1);
        start_run(2'd1, 16'd3, 32'd0);
        chk("busy_after_start", 32'(busy_o), 32'd1);
        chk("min_cleared", len_min_o, 32'hFFFF_FFFF);
        burst(1, 4, 3);
        burst(1, 7, 3);
        burst(1, 2, 6);
        chk("idle_after_done", 32'(busy_o), 32'd0);
        chk("hold_total", total_o, 32'd13);

        // Burst in progress at start is skipped
        s_tvalid_i[2] = 1'b1;
        repeat (5) @(negedge clk);
        expect_run(1, 5, 5, 5, 5, 1'b0, -1);
        start_run(2'd2, 16'd1, 32'd0);
        repeat (4) @(negedge clk);
        s_tvalid_i[2] = 1'b0;
        repeat (3) @(negedge clk);
        burst(2, 5, 6);

        // Timeout after two bursts
        start_run(2'd0, 16'd4, 32'd100);
        expect_run(2, 3, 3, 3, 6, 1'b1, start_cyc + 101);
        burst(0, 3, 3);
        burst(0, 3, 3);
        repeat (100) @(negedge clk);
        chk("timeout_sticky", 32'(timeout_o), 32'd1);

        // Timeout with no bursts at all
        start_run(2'd0, 16'd1, 32'd5);
        expect_run(0, 0, 32'hFFFF_FFFF, 0, 0, 1'b1, start_cyc + 6);
        repeat (10) @(negedge clk);

        // Abort together with start in MEAS
        start_run(2'd3, 16'd2, 32'd0);
        burst(3, 4, 3);
        s_tvalid_i[3] = 1'b1;
        repeat (3) @(negedge clk);
        abort_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_cnt", 32'(burst_cnt_o), 32'd1);
        chk("abort_last", len_last_o, 32'd4);
        chk("abort_total", total_o, 32'd4);
        s_tvalid_i[3] = 1'b0;
        repeat (4) @(negedge clk);
        chk("start_dropped", 32'(busy_o), 32'd0);
        expect_run(2, 6, 3, 6, 9, 1'b0, -1);
        start_run(2'd3, 16'd2, 32'd0);
        chk("restart_cnt", 32'(burst_cnt_o), 32'd0);
        burst(3, 3, 2);
        burst(3, 6, 6);

        // nburst=0, ignored restart and ignored channel change
        expect_run(1, 5, 5, 5, 5, 1'b0, -1);
        start_run(2'd0, 16'd0, 32'd0);
        ch_sel_i  = 2'd1;
        nburst_i  = 16'd5;
        timeout_i = 32'd3;
        start_i   = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        burst(1, 8, 2);
        burst(0, 5, 6);
        chk("nb0_idle", 32'(busy_o), 32'd0);

        // Timeout coincides with final burst end
        start_run(2'd0, 16'd2, 32'd11);
        expect_run(2, 4, 3, 4, 7, 1'b0, start_cyc + 12);
        burst(0, 3, 2);
        burst(0, 4, 5);
        chk("coincide_no_timeout", 32'(timeout_o), 32'd0);

`ifdef AXIS_BURST_MEAS_GAP_EN
        expect_run(4, 2, 2, 2, 8, 1'b0, -1);
        start_run(2'd0, 16'd4, 32'd0);
        repeat (12) @(negedge clk);
        burst(0, 2, 3);
        burst(0, 2, 9);
        burst(0, 2, 5);
        burst(0, 2, 6);
        chk("gap_max", gap_max_o, 32'd9);
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
